// File: rtl/biu_bus_controller_if.sv
// biu_bus_controller_if: EU request, memory handshake and datapath-control bundle
// shared by the BIU sequencer and its surroundings.
interface biu_bus_controller_if;
    logic       eu_req;
    logic       eu_wr;
    logic [2:0] eu_op;
    logic       q_pop;
    logic       flush;
    logic       mem_ready;
    logic       ale;
    logic       rd_wr;
    logic       bus_oe;
    logic [2:0] alu_op;
    logic       ip_en;
    logic       ip_sel;
    logic       q_push;
    logic [2:0] q_count;
    logic       q_full;
    logic       eu_ack;
    logic       bus_err;
    logic       busy;

    modport master (
        input  eu_req, eu_wr, eu_op, q_pop, flush, mem_ready,
        output ale, rd_wr, bus_oe, alu_op, ip_en, ip_sel, q_push, q_count, q_full,
               eu_ack, bus_err, busy
    );

    modport slave (
        output eu_req, eu_wr, eu_op, q_pop, flush, mem_ready,
        input  ale, rd_wr, bus_oe, alu_op, ip_en, ip_sel, q_push, q_count, q_full,
               eu_ack, bus_err, busy
    );
endinterface

// File: rtl/biu_bus_controller.sv
// biu_bus_controller: T1-T4 bus-cycle sequencer arbitrating EU data cycles against
// code prefetch, with instruction-queue occupancy tracking and flush handling.
module biu_bus_controller #(
    parameter int         QUEUE_DEPTH = 6,
    parameter logic [2:0] CODE_OP     = 3'b000,
    parameter int         TW_MAX      = 15
) (
    input logic                  clk,
    input logic                  reset,
    biu_bus_controller_if.master bus
);
    localparam int WW = $clog2(TW_MAX + 1);

    typedef enum logic [2:0] {IDLE, T1, T2, T3, TW, T4} state_t;

    state_t        state, state_nxt;
    logic          cyc_eu, cyc_wr, flushed;
    logic [WW-1:0] wcnt;
    logic [2:0]    count_nxt;
    logic          pop_ok, grant_eu, grant_fetch, timeout, to_t4, fetch_done, mid;

    always_comb begin
        pop_ok      = bus.q_pop && bus.q_count != 3'd0;
        count_nxt   = bus.flush ? 3'd0 : bus.q_count + {2'd0, bus.q_push} - {2'd0, pop_ok};
        // the request still visible during our own ack belongs to the finished cycle
        grant_eu    = bus.eu_req && !(state == T4 && cyc_eu);
        grant_fetch = !bus.flush && int'(count_nxt) < QUEUE_DEPTH;
        timeout     = state == TW && !bus.mem_ready && wcnt == WW'(TW_MAX - 1);
        state_nxt   = (state == IDLE || state == T4) ? ((grant_eu || grant_fetch) ? T1 : IDLE) :
                      state == T1 ? T2 :
                      state == T2 ? T3 :
                      (state == T3 || state == TW) ? ((bus.mem_ready || timeout) ? T4 : TW) :
                      IDLE;
        to_t4       = state_nxt == T4;
        fetch_done  = to_t4 && !cyc_eu && !flushed && !bus.flush;
        mid         = state_nxt != IDLE && state_nxt != T1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cyc_eu      <= 1'b0;
            cyc_wr      <= 1'b0;
            flushed     <= 1'b0;
            wcnt        <= '0;
            bus.ale     <= 1'b0;
            bus.rd_wr   <= 1'b1;
            bus.bus_oe  <= 1'b0;
            bus.alu_op  <= CODE_OP;
            bus.ip_en   <= 1'b0;
            bus.ip_sel  <= 1'b0;
            bus.q_push  <= 1'b0;
            bus.q_count <= 3'd0;
            bus.q_full  <= 1'b0;
            bus.eu_ack  <= 1'b0;
            bus.bus_err <= 1'b0;
            bus.busy    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt == T1) begin
                cyc_eu     <= grant_eu;
                cyc_wr     <= grant_eu && bus.eu_wr;
                bus.alu_op <= grant_eu ? bus.eu_op : CODE_OP;
            end
            flushed     <= state != T4 && (flushed || (bus.flush && state != IDLE && !cyc_eu));
            wcnt        <= state == TW ? wcnt + 1'b1 : '0;
            bus.ale     <= state_nxt == T1;
            bus.rd_wr   <= !(cyc_wr && mid);
            bus.bus_oe  <= cyc_wr && mid;
            bus.q_push  <= fetch_done;
            bus.ip_en   <= bus.flush || fetch_done;
            bus.ip_sel  <= bus.flush;
            bus.eu_ack  <= to_t4 && cyc_eu;
            bus.bus_err <= timeout;
            bus.q_count <= count_nxt;
            bus.q_full  <= int'(count_nxt) == QUEUE_DEPTH;
            bus.busy    <= state_nxt != IDLE;
        end
    end
endmodule

// File: tb/tb_biu_bus_controller.sv
// tb_biu_bus_controller: vector table plus hand sequences; q_push/eu_ack/bus_err pulses
// are scoreboarded against the clock number at which they must appear.
module tb_biu_bus_controller;
    logic clk = 1'b0;
    logic reset = 1'b0;

    biu_bus_controller_if bus ();
    biu_bus_controller dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        logic [2:0] kind;
    } ev_t;

    typedef struct {
        logic       eu_req;
        logic       eu_wr;
        logic [2:0] eu_op;
        logic       q_pop;
        int         ev_dt;
        logic [2:0] ev_kind;
        logic [9:0] exp;
    } vec_t;

    ev_t  sb[$];
    vec_t vecs[9];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // kind = {bus_err, eu_ack, q_push}
    task automatic expect_ev(input int dt, input logic [2:0] kind);
        sb.push_back('{cyc + dt, kind});
    endtask

    task automatic monitor();
        logic [2:0] ev;
        ev_t e;
        ev = {bus.bus_err, bus.eu_ack, bus.q_push};
        while (sb.size() != 0 && sb[0].at < cyc) begin
            e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missed_event: got none expected kind %03b at cycle %0d", e.kind, e.at);
        end
        if (ev != 3'b000) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: got kind %03b at cycle %0d expected none", ev, cyc);
            end else begin
                e = sb.pop_front();
                check("event_cycle", cyc, e.at);
                check("event_kind", {29'd0, ev}, {29'd0, e.kind});
            end
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            monitor();
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        // exp = {ale, rd_wr, bus_oe, busy, alu_op, q_count}
        vecs[0] = '{1'b0, 1'b0, 3'b000, 1'b1, 4, 3'b001, 10'b0_1_0_0_000_110};
        vecs[1] = '{1'b0, 1'b0, 3'b000, 1'b0, 0, 3'b000, 10'b1_1_0_1_000_101};
        vecs[2] = '{1'b1, 1'b1, 3'b101, 1'b0, 6, 3'b010, 10'b0_1_0_1_000_101};
        vecs[3] = '{1'b1, 1'b1, 3'b101, 1'b0, 0, 3'b000, 10'b0_1_0_1_000_101};
        vecs[4] = '{1'b1, 1'b1, 3'b101, 1'b0, 0, 3'b000, 10'b0_1_0_1_000_101};
        vecs[5] = '{1'b1, 1'b1, 3'b101, 1'b0, 0, 3'b000, 10'b1_1_0_1_101_110};
        vecs[6] = '{1'b1, 1'b1, 3'b101, 1'b0, 0, 3'b000, 10'b0_0_1_1_101_110};
        vecs[7] = '{1'b1, 1'b1, 3'b101, 1'b0, 0, 3'b000, 10'b0_0_1_1_101_110};
        vecs[8] = '{1'b0, 1'b1, 3'b101, 1'b0, 0, 3'b000, 10'b0_0_1_1_101_110};

        bus.eu_req = 1'b0; bus.eu_wr = 1'b0; bus.eu_op = 3'b000;
        bus.q_pop = 1'b0; bus.flush = 1'b0; bus.mem_ready = 1'b1;
        tick(3);
        check("rst_ale", bus.ale, 0);
        check("rst_rd_wr", bus.rd_wr, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_q_count", bus.q_count, 0);
        check("rst_alu_op", bus.alu_op, 0);
        check("rst_misc", {bus.bus_oe, bus.ip_en, bus.ip_sel, bus.q_push, bus.q_full, bus.eu_ack, bus.bus_err}, 0);

        // fill from empty: pushes at clocks 4, 8, ..., 24
        reset = 1'b1;
        cyc = 0;
        for (int i = 1; i <= 6; i++) expect_ev(4 * i, 3'b001);
        tick();
        check("fill_t1_ale", bus.ale, 1);
        check("fill_t1_busy", bus.busy, 1);
        tick(24);
        check("fill_q_count", bus.q_count, 6);
        check("fill_q_full", bus.q_full, 1);
        check("fill_idle", bus.busy, 0);
        tick();
        check("full_stays_idle", bus.busy, 0);

        // one pop at full queue refetches on the next clock
        bus.q_pop = 1'b1;
        expect_ev(4, 3'b001);
        tick();
        bus.q_pop = 1'b0;
        check("pop_q_count", bus.q_count, 5);
        check("pop_q_full", bus.q_full, 0);
        check("pop_refetch_ale", bus.ale, 1);
        tick(4);
        check("refill_q_count", bus.q_count, 6);
        check("refill_q_full", bus.q_full, 1);
        check("refill_idle", bus.busy, 0);

        // EU write raised during fetch T2 runs right after the fetch T4
        for (int i = 0; i < 9; i++) begin
            bus.eu_req = vecs[i].eu_req;
            bus.eu_wr  = vecs[i].eu_wr;
            bus.eu_op  = vecs[i].eu_op;
            bus.q_pop  = vecs[i].q_pop;
            if (vecs[i].ev_kind != 3'b000) expect_ev(vecs[i].ev_dt, vecs[i].ev_kind);
            check($sformatf("vec%0d", i),
                  {22'd0, bus.ale, bus.rd_wr, bus.bus_oe, bus.busy, bus.alu_op, bus.q_count},
                  {22'd0, vecs[i].exp});
            tick();
        end
        bus.eu_wr = 1'b0;
        check("eu_done_idle", {bus.rd_wr, bus.bus_oe, bus.busy}, 3'b100);

        // three wait states: 7-clock cycle
        bus.q_pop = 1'b1;
        expect_ev(7, 3'b001);
        tick();
        bus.q_pop = 1'b0;
        tick(2);
        bus.mem_ready = 1'b0;
        tick();
        check("tw_busy", {bus.ale, bus.busy}, 2'b01);
        tick(2);
        bus.mem_ready = 1'b1;
        tick(2);
        check("tw_done_idle", bus.busy, 0);
        check("tw_done_q_count", bus.q_count, 6);

        // memory never ready: bus_err after TW_MAX waits
        bus.q_pop = 1'b1;
        bus.mem_ready = 1'b0;
        expect_ev(19, 3'b101);
        tick();
        bus.q_pop = 1'b0;
        tick(11);
        check("timeout_waiting", {bus.ale, bus.busy, bus.bus_err}, 3'b010);
        tick(7);
        bus.mem_ready = 1'b1;
        tick();
        check("timeout_idle", bus.busy, 0);
        check("timeout_err_pulse", bus.bus_err, 0);
        check("timeout_q_count", bus.q_count, 6);

        // flush in fetch T2 at q_count 4
        bus.q_pop = 1'b1;
        tick(2);
        bus.q_pop = 1'b0;
        check("pre_flush_q_count", bus.q_count, 4);
        bus.flush = 1'b1;
        for (int i = 0; i < 6; i++) expect_ev(6 + 4 * i, 3'b001);
        tick();
        bus.flush = 1'b0;
        check("flush_q_count", bus.q_count, 0);
        check("flush_ip_load", {bus.ip_en, bus.ip_sel}, 2'b11);
        tick();
        check("flushed_t4", {bus.ip_en, bus.q_push, bus.busy}, 3'b001);
        tick();
        check("after_flush_ale", bus.ale, 1);
        tick(24);
        check("flush_refill_q_count", bus.q_count, 6);
        check("flush_refill_q_full", bus.q_full, 1);

        // push and pop together at q_count 3
        bus.q_pop = 1'b1;
        for (int i = 1; i <= 4; i++) expect_ev(4 * i, 3'b001);
        tick(3);
        bus.q_pop = 1'b0;
        check("pre_pushpop_q_count", bus.q_count, 3);
        tick();
        bus.q_pop = 1'b1;
        check("pushpop_base", bus.q_count, 3);
        tick();
        bus.q_pop = 1'b0;
        check("pushpop_q_count", bus.q_count, 3);
        tick(12);
        check("pushpop_refill", {bus.busy, bus.q_count}, 4'b0110);

        // flush while idle, then pop at an empty queue
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("idle_flush_q_count", bus.q_count, 0);
        bus.q_pop = 1'b1;
        for (int i = 1; i <= 6; i++) expect_ev(4 * i, 3'b001);
        tick();
        bus.q_pop = 1'b0;
        check("pop_at_zero", bus.q_count, 0);
        check("pop_at_zero_ale", bus.ale, 1);
        tick(24);
        check("zero_refill", {bus.busy, bus.q_count}, 4'b0110);

        // EU read whose request drops during T1 still acks, no reissue
        bus.eu_req = 1'b1;
        bus.eu_wr = 1'b0;
        bus.eu_op = 3'b011;
        expect_ev(4, 3'b010);
        tick();
        bus.eu_req = 1'b0;
        check("eu_rd_t1", {bus.ale, bus.alu_op}, 4'b1011);
        tick();
        check("eu_rd_t2", {bus.rd_wr, bus.bus_oe}, 2'b10);
        tick(3);
        check("eu_no_reissue", bus.busy, 0);

        // reset in the middle of a fetch
        bus.q_pop = 1'b1;
        tick();
        bus.q_pop = 1'b0;
        tick(2);
        check("pre_reset_busy", {bus.busy, bus.q_count}, 4'b1101);
        reset = 1'b0;
        #1;
        check("mid_rst_state", {bus.busy, bus.ale, bus.rd_wr, bus.bus_oe, bus.q_push}, 5'b00100);
        check("mid_rst_q_count", bus.q_count, 0);
        check("mid_rst_alu_op", bus.alu_op, 0);
        tick(2);
        check("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/biu_bus_controller.md
Name: biu_bus_controller

Overview:
- Sequencer for the bus interface unit: runs the T1–T4 bus-cycle state machine that drives the I/O buffer direction, ALU addressing mode, IP register update and instruction queue push.
- Arbitrates the bus between the execution unit (EU) data requests and the code prefetcher.
- Tracks queue occupancy so prefetch stops when the queue is full.
- Sits between the EU and the existing register bank / segments / RegIP / ALU / queue / buffer datapath.

Parameters:
- QUEUE_DEPTH, 6: instruction queue capacity in bytes.
- CODE_OP, 3'b000: ALU addressing mode used for code fetch (CS:IP).
- TW_MAX, 15: maximum wait states before a bus error is forced.

Ports:
- clk in 1: system clock, rising edge.
- reset in 1: asynchronous, active-low reset.
- eu_req in 1: EU requests a data bus cycle; held until eu_ack.
- eu_wr in 1: 1 = EU write, 0 = EU read; sampled with eu_req.
- eu_op in 3: ALU addressing mode for the EU cycle; sampled with eu_req.
- q_pop in 1: EU consumed one queue byte this cycle.
- flush in 1: jump taken; discard queue contents and load IP.
- mem_ready in 1: memory ready, sampled in T3/TW.
- ale out 1: address latch enable, high during T1 only.
- rd_wr out 1: Internal_RD_WR to the buffer; 1 = read, 0 = write.
- bus_oe out 1: drive data bus; high in T2–T4 of write cycles.
- alu_op out 3: addressing mode to ALU OP, held constant T1–T4.
- ip_en out 1: RegIP EN.
- ip_sel out 1: RegIP SEL; 0 = increment, 1 = load.
- q_push out 1: queue EN, one-cycle pulse.
- q_count out 3: bytes currently in queue.
- q_full out 1: q_count == QUEUE_DEPTH.
- eu_ack out 1: one-cycle pulse in T4 of an EU cycle.
- bus_err out 1: one-cycle pulse in T4 when a wait timeout occurred.
- busy out 1: state != IDLE.

Behaviour:
- Reset (reset = 0, async):
  - state = IDLE, q_count = 0, wait counter = 0.
  - alu_op = CODE_OP, rd_wr = 1.
  - All other outputs 0.
- States: IDLE, T1, T2, T3, TW, T4. Registered outputs, decoded from state.
- Arbitration, evaluated in IDLE and in T4:
  - eu_req = 1 → start EU cycle (EU has priority).
  - Else q_count < QUEUE_DEPTH and not flushing → start fetch cycle.
  - Else → IDLE.
  - No preemption of a running cycle.
- T1:
  - ale = 1.
  - alu_op = eu_op (EU cycle) or CODE_OP (fetch).
  - Cycle type latched here.
- T2:
  - rd_wr = ~eu_wr for EU cycles, 1 for fetch.
  - bus_oe = 1 if write.
- T3:
  - mem_ready = 1 → T4.
  - mem_ready = 0 → TW; wait counter cleared.
- TW:
  - Wait counter increments each cycle.
  - mem_ready = 1 → T4.
  - Counter == TW_MAX → T4 with bus_err.
- T4, fetch cycle:
  - q_push = 1 and ip_en = 1, ip_sel = 0, unless the cycle was flushed.
- T4, EU cycle:
  - eu_ack = 1.
- T4 exit: → T1 if a new cycle is granted, else IDLE.
- Latency and throughput:
  - Zero-wait cycle = 4 clocks (T1 to T4 inclusive).
  - Back-to-back cycles: T4 → T1, no idle clock.
- Queue count update each clock:
  - +1 on q_push.
  - −1 on q_pop when q_count > 0.
  - push and pop together → unchanged.
  - q_pop at 0 → ignored.
- Only one fetch is in flight, and it starts only when q_count ≤ QUEUE_DEPTH−1, so the count never exceeds QUEUE_DEPTH.
- Flush:
  - q_count := 0 next clock; overrides push and pop.
  - ip_en = 1, ip_sel = 1 for one cycle.
  - If a fetch is in progress: it completes on the bus, its T4 push and IP increment are suppressed, and the flushed flag clears at T4.
  - An EU cycle in progress is unaffected.
- eu_req deasserted before ack: a cycle already started still completes and acks; no new EU cycle is started.
- Reset mid-cycle: immediate return to the reset values; no partial push or ack.

Test Plan:
- Reset release, no requests, no pops → fetches start immediately.
  - Six fetches in 24 clocks; q_push pulses at clocks 4, 8, …, 24.
  - q_count reaches 6, q_full = 1, then IDLE, busy = 0.
- Queue full, one q_pop → q_count = 5.
  - Fetch starts next clock; push 4 clocks later; q_full returns to 1.
- eu_req = 1, eu_wr = 1, eu_op = 3'b101 asserted during fetch T2:
  - Fetch finishes first.
  - EU T1 follows T4 directly with alu_op = 101, rd_wr = 0, bus_oe in T2–T4.
  - eu_ack in its T4.
- mem_ready low for 3 clocks in T3 → 3 TW cycles, T4 on the 4th; total cycle = 7 clocks.
  - mem_ready held low → bus_err pulse after TW_MAX waits.
- flush in fetch T2 with q_count = 4:
  - q_count = 0 next clock; ip_en/ip_sel = 1/1 for one cycle.
  - No q_push or IP increment at that T4; next fetch pushes normally.
- q_push and q_pop in the same clock at q_count = 3 → q_count stays 3.
  - q_pop at q_count = 0 → stays 0.
